// File: rtl/int_res_map_if.sv
// Programming and lookup bus between the inference controller and the
// intermediate-result map table.
interface int_res_map_if #(
  parameter int NUM_ENTRIES = 20,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_SIZE   = 14336,
  parameter int ADDR_W      = $clog2(NUM_BANKS * BANK_SIZE),
  parameter int FMT_W       = 3,
  parameter int NUM_PORTS   = 2
);
  localparam int IDX_W   = $clog2(NUM_ENTRIES);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int BADDR_W = $clog2(BANK_SIZE);

  logic                           cfg_start;
  logic                           cfg_valid;
  logic                           cfg_ready;
  logic [IDX_W-1:0]               cfg_idx;
  logic [ADDR_W-1:0]              cfg_base;
  logic                           cfg_width;
  logic [FMT_W-1:0]               cfg_fmt;
  logic                           cfg_commit;
  logic                           cfg_err;
  logic                           locked;

  logic [NUM_PORTS-1:0]           lk_valid;
  logic [NUM_PORTS*IDX_W-1:0]     lk_idx;
  logic [NUM_PORTS*ADDR_W-1:0]    lk_offset;
  logic [NUM_PORTS-1:0]           rsp_valid;
  logic [NUM_PORTS*BANK_W-1:0]    rsp_bank;
  logic [NUM_PORTS*BADDR_W-1:0]   rsp_bank_addr;
  logic [NUM_PORTS-1:0]           rsp_width;
  logic [NUM_PORTS*FMT_W-1:0]     rsp_fmt;
  logic [NUM_PORTS-1:0]           rsp_err;

  modport master (
    output cfg_start, cfg_valid, cfg_idx, cfg_base, cfg_width, cfg_fmt, cfg_commit,
    output lk_valid, lk_idx, lk_offset,
    input  cfg_ready, cfg_err, locked,
    input  rsp_valid, rsp_bank, rsp_bank_addr, rsp_width, rsp_fmt, rsp_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_idx, cfg_base, cfg_width, cfg_fmt, cfg_commit,
    input  lk_valid, lk_idx, lk_offset,
    output cfg_ready, cfg_err, locked,
    output rsp_valid, rsp_bank, rsp_bank_addr, rsp_width, rsp_fmt, rsp_err
  );
endinterface

// File: rtl/int_res_map_table.sv
// Runtime-programmable descriptor table mapping (step, offset) lookups onto
// intermediate-result bank selects and bank-local addresses.
module int_res_map_table #(
  parameter int NUM_ENTRIES = 20,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_SIZE   = 14336,
  parameter int ADDR_W      = $clog2(NUM_BANKS * BANK_SIZE),
  parameter int FMT_W       = 3,
  parameter int NUM_PORTS   = 2
) (
  input  logic          clk,
  input  logic          rst,
  int_res_map_if.slave  bus
);
  localparam int IDX_W   = $clog2(NUM_ENTRIES);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int BADDR_W = $clog2(BANK_SIZE);
  localparam int FLAT_W  = ADDR_W + 1;
  localparam int TOTAL   = NUM_BANKS * BANK_SIZE;

  typedef enum logic [1:0] {UNPROG = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;

  state_t                 state_r, state_nxt_s;
  logic                   cfg_err_r, locked_r, cfg_ready_r;
  logic                   err_set_s, err_clr_s;
  logic                   cfg_idx_ok_s, wr_en_s, all_written_s;
  logic [NUM_ENTRIES-1:0] written_r, wr_mask_s;

  logic [ADDR_W-1:0]      base_r [NUM_ENTRIES];
  logic [FMT_W-1:0]       fmt_r  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] width_r;

  logic [IDX_W-1:0]       lk_idx_s   [NUM_PORTS];
  logic [ADDR_W-1:0]      ent_base_s [NUM_PORTS];
  logic [FMT_W-1:0]       ent_fmt_s  [NUM_PORTS];
  logic [FLAT_W-1:0]      flat_s     [NUM_PORTS];
  logic [NUM_PORTS-1:0]   idx_ok_s, ent_width_s, err_s;

  logic [NUM_PORTS-1:0]   v1_r, err1_r, width1_r;
  logic [FLAT_W-1:0]      flat1_r [NUM_PORTS];
  logic [FMT_W-1:0]       fmt1_r  [NUM_PORTS];

  logic [BANK_W-1:0]      bank_s      [NUM_PORTS];
  logic [FLAT_W-1:0]      bank_base_s [NUM_PORTS];

  logic [NUM_PORTS-1:0]           rsp_valid_r, rsp_width_r, rsp_err_r;
  logic [NUM_PORTS*BANK_W-1:0]    rsp_bank_r;
  logic [NUM_PORTS*BADDR_W-1:0]   rsp_bank_addr_r;
  logic [NUM_PORTS*FMT_W-1:0]     rsp_fmt_r;

  assign cfg_idx_ok_s  = 32'(bus.cfg_idx) < NUM_ENTRIES;
  assign wr_en_s       = (state_r == LOAD) && bus.cfg_valid && cfg_idx_ok_s;
  // A same-cycle write counts towards the commit completeness check.
  assign all_written_s = &(written_r | wr_mask_s);

  // One-hot mask of the entry being written this cycle.
  always_comb begin
    wr_mask_s = '0;
    if (wr_en_s) begin
      wr_mask_s[bus.cfg_idx] = 1'b1;
    end else begin
      wr_mask_s = '0;
    end
  end

  // Programming FSM: next state and sticky-error set/clear requests.
  always_comb begin
    state_nxt_s = state_r;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    case (state_r)
      UNPROG: begin
        if (bus.cfg_start) begin
          state_nxt_s = LOAD;
          err_clr_s   = 1'b1;
        end else begin
          state_nxt_s = UNPROG;
        end
      end
      LOAD: begin
        err_set_s = bus.cfg_valid && !cfg_idx_ok_s;
        if (bus.cfg_commit && all_written_s) begin
          state_nxt_s = READY;
        end else if (bus.cfg_commit) begin
          state_nxt_s = UNPROG;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      READY: begin
        err_set_s = bus.cfg_valid;
        if (bus.cfg_start) begin
          state_nxt_s = LOAD;
          err_clr_s   = 1'b1;
        end else begin
          state_nxt_s = READY;
        end
      end
      default: begin
        state_nxt_s = UNPROG;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= UNPROG;
      cfg_err_r   <= 1'b0;
      locked_r    <= 1'b0;
      cfg_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cfg_err_r   <= err_set_s | (cfg_err_r & ~err_clr_s);
      locked_r    <= (state_nxt_s == READY);
      cfg_ready_r <= (state_nxt_s == LOAD);
    end
  end

  // Descriptor storage; contents survive a reprogramming session until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        base_r[i] <= '0;
        fmt_r[i]  <= '0;
      end
      width_r   <= '0;
      written_r <= '0;
    end else if (wr_en_s) begin
      base_r[bus.cfg_idx]  <= bus.cfg_base;
      fmt_r[bus.cfg_idx]   <= bus.cfg_fmt;
      width_r[bus.cfg_idx] <= bus.cfg_width;
      written_r            <= written_r | wr_mask_s;
    end
  end

  // Stage 1 combinational: descriptor read, flat address and range check.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      lk_idx_s[p] = bus.lk_idx[p*IDX_W +: IDX_W];
      idx_ok_s[p] = 32'(lk_idx_s[p]) < NUM_ENTRIES;
      if (idx_ok_s[p]) begin
        ent_base_s[p]  = base_r[lk_idx_s[p]];
        ent_fmt_s[p]   = fmt_r[lk_idx_s[p]];
        ent_width_s[p] = width_r[lk_idx_s[p]];
      end else begin
        ent_base_s[p]  = '0;
        ent_fmt_s[p]   = '0;
        ent_width_s[p] = 1'b0;
      end
      flat_s[p] = {1'b0, ent_base_s[p]} + {1'b0, bus.lk_offset[p*ADDR_W +: ADDR_W]};
      err_s[p]  = !locked_r || !idx_ok_s[p] || (flat_s[p] >= FLAT_W'(TOTAL));
    end
  end

  // Stage 1 pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r     <= '0;
      err1_r   <= '0;
      width1_r <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        flat1_r[p] <= '0;
        fmt1_r[p]  <= '0;
      end
    end else begin
      v1_r     <= bus.lk_valid;
      err1_r   <= err_s;
      width1_r <= ent_width_s;
      for (int p = 0; p < NUM_PORTS; p++) begin
        flat1_r[p] <= flat_s[p];
        fmt1_r[p]  <= ent_fmt_s[p];
      end
    end
  end

  // Stage 2 combinational: thermometer compare against bank boundaries, last hit wins.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_s[p]      = '0;
      bank_base_s[p] = '0;
      for (int k = 1; k < NUM_BANKS; k++) begin
        bank_s[p]      = (flat1_r[p] >= FLAT_W'(k * BANK_SIZE)) ? BANK_W'(k) : bank_s[p];
        bank_base_s[p] = (flat1_r[p] >= FLAT_W'(k * BANK_SIZE)) ? FLAT_W'(k * BANK_SIZE)
                                                                 : bank_base_s[p];
      end
    end
  end

  // Stage 2 registers drive the response outputs; errored lookups carry no address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r     <= '0;
      rsp_err_r       <= '0;
      rsp_width_r     <= '0;
      rsp_bank_r      <= '0;
      rsp_bank_addr_r <= '0;
      rsp_fmt_r       <= '0;
    end else begin
      rsp_valid_r <= v1_r;
      rsp_err_r   <= err1_r;
      rsp_width_r <= width1_r;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_fmt_r[p*FMT_W +: FMT_W]         <= fmt1_r[p];
        rsp_bank_r[p*BANK_W +: BANK_W]      <= err1_r[p] ? '0 : bank_s[p];
        rsp_bank_addr_r[p*BADDR_W +: BADDR_W] <=
          err1_r[p] ? '0 : BADDR_W'(flat1_r[p] - bank_base_s[p]);
      end
    end
  end

  assign bus.cfg_ready     = cfg_ready_r;
  assign bus.cfg_err       = cfg_err_r;
  assign bus.locked        = locked_r;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_bank      = rsp_bank_r;
  assign bus.rsp_bank_addr = rsp_bank_addr_r;
  assign bus.rsp_width     = rsp_width_r;
  assign bus.rsp_fmt       = rsp_fmt_r;
  assign bus.rsp_err       = rsp_err_r;
endmodule

// File: tb/tb_int_res_map_table.sv
// Directed bench for int_res_map_table: a behavioural table/pipeline model is
// checked against the DUT every cycle, plus hand-computed literal checks.
module tb_int_res_map_table;
  localparam int NE  = 20;
  localparam int NB  = 4;
  localparam int BS  = 14336;
  localparam int AW  = 16;
  localparam int FW  = 3;
  localparam int NP  = 2;
  localparam int IW  = 5;
  localparam int BW  = 2;
  localparam int BAW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_res_map_if #(.NUM_ENTRIES(NE), .NUM_BANKS(NB), .BANK_SIZE(BS), .ADDR_W(AW),
                   .FMT_W(FW), .NUM_PORTS(NP)) bus ();

  int_res_map_table #(.NUM_ENTRIES(NE), .NUM_BANKS(NB), .BANK_SIZE(BS), .ADDR_W(AW),
                      .FMT_W(FW), .NUM_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    bit err;
    int bank;
    int addr;
    int width;
    int fmt;
  } rsp_t;

  int   m_base [NE];
  int   m_width[NE];
  int   m_fmt  [NE];
  bit   m_wr   [NE];
  bit   m_loading, m_locked, m_err;
  rsp_t p1[NP];
  rsp_t p2[NP];
  int   total = 0;
  int   bad   = 0;

  function automatic int ent_base(int i);
    if (i == 0) return 0;
    if (i == 2) return 3840;
    if (i == 4) return 20000;
    if (i == 18) return 57334;
    return i * 2800;
  endfunction

  function automatic int ent_width(int i);
    return (i == 4) ? 1 : (i % 2);
  endfunction

  function automatic int ent_fmt(int i);
    return (i == 4) ? 5 : (i % 8);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int d_bank(int p);
    return int'(bus.rsp_bank[p*BW +: BW]);
  endfunction

  function automatic int d_addr(int p);
    return int'(bus.rsp_bank_addr[p*BAW +: BAW]);
  endfunction

  // Advance one clock: update the model from the inputs the DUT is about to
  // sample, then compare every meaningful output after the edge.
  task automatic cycle();
    rsp_t n[NP];
    bit   all;
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        m_base[i] = 0; m_width[i] = 0; m_fmt[i] = 0; m_wr[i] = 1'b0;
      end
      m_loading = 1'b0; m_locked = 1'b0; m_err = 1'b0;
      for (int p = 0; p < NP; p++) begin
        p1[p].v = 1'b0; p2[p].v = 1'b0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        int idx, off, flat;
        idx = int'(bus.lk_idx[p*IW +: IW]);
        off = int'(bus.lk_offset[p*AW +: AW]);
        n[p].v = bus.lk_valid[p];
        if (idx < NE) begin
          flat = m_base[idx] + off;
          n[p].width = m_width[idx];
          n[p].fmt   = m_fmt[idx];
        end else begin
          flat = 0;
          n[p].width = 0;
          n[p].fmt   = 0;
        end
        n[p].err  = !m_locked || idx >= NE || flat >= NB * BS;
        n[p].bank = n[p].err ? 0 : flat / BS;
        n[p].addr = n[p].err ? 0 : flat % BS;
      end
      p2 = p1;
      p1 = n;
      if (m_loading) begin
        if (bus.cfg_valid) begin
          if (int'(bus.cfg_idx) < NE) begin
            m_base[bus.cfg_idx]  = int'(bus.cfg_base);
            m_width[bus.cfg_idx] = int'(bus.cfg_width);
            m_fmt[bus.cfg_idx]   = int'(bus.cfg_fmt);
            m_wr[bus.cfg_idx]    = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
        if (bus.cfg_commit) begin
          all = 1'b1;
          for (int i = 0; i < NE; i++) if (!m_wr[i]) all = 1'b0;
          m_loading = 1'b0;
          if (all) m_locked = 1'b1;
          else m_err = 1'b1;
        end
      end else if (m_locked) begin
        if (bus.cfg_start) begin
          m_err = 1'b0; m_loading = 1'b1; m_locked = 1'b0;
        end
        if (bus.cfg_valid) m_err = 1'b1;
      end else if (bus.cfg_start) begin
        m_loading = 1'b1;
        m_err = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("cfg_ready", int'(bus.cfg_ready), int'(m_loading));
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("cfg_err", int'(bus.cfg_err), int'(m_err));
    for (int p = 0; p < NP; p++) begin
      chk("rsp_valid", int'(bus.rsp_valid[p]), int'(p2[p].v));
      if (p2[p].v) begin
        chk("rsp_err", int'(bus.rsp_err[p]), int'(p2[p].err));
        chk("rsp_bank", d_bank(p), p2[p].bank);
        chk("rsp_bank_addr", d_addr(p), p2[p].addr);
        chk("rsp_width", int'(bus.rsp_width[p]), p2[p].width);
        chk("rsp_fmt", int'(bus.rsp_fmt[p*FW +: FW]), p2[p].fmt);
      end
    end
  endtask

  task automatic clr_inputs();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
    bus.cfg_idx = '0; bus.cfg_base = '0; bus.cfg_width = 1'b0; bus.cfg_fmt = '0;
    bus.lk_valid = '0; bus.lk_idx = '0; bus.lk_offset = '0;
  endtask

  task automatic set_cfg(int idx, int base, int w, int f);
    bus.cfg_valid = 1'b1;
    bus.cfg_idx   = IW'(idx);
    bus.cfg_base  = AW'(base);
    bus.cfg_width = w[0];
    bus.cfg_fmt   = FW'(f);
  endtask

  task automatic write_entry(int i);
    set_cfg(i, ent_base(i), ent_width(i), ent_fmt(i));
    cycle();
    clr_inputs();
  endtask

  task automatic set_lk(int p, int idx, int off);
    bus.lk_valid[p] = 1'b1;
    bus.lk_idx[p*IW +: IW]    = IW'(idx);
    bus.lk_offset[p*AW +: AW] = AW'(off);
  endtask

  task automatic pulse(bit start, bit commit);
    bus.cfg_start  = start;
    bus.cfg_commit = commit;
    cycle();
    clr_inputs();
  endtask

  task automatic sweep();
    for (int i = 0; i < NE; i++) begin
      set_lk(0, i, i * 7);
      set_lk(1, NE - 1 - i, 100);
      cycle();
      clr_inputs();
    end
    cycle();
    cycle();
  endtask

  initial begin
    clr_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_cfg_ready", int'(bus.cfg_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    rst = 1'b0;
    cycle();

    // Session with entries 7 and 19 missing: commit must fail.
    pulse(1'b1, 1'b0);
    chk("load_cfg_ready", int'(bus.cfg_ready), 1);
    for (int i = 0; i < NE - 1; i++) if (i != 7) write_entry(i);
    pulse(1'b0, 1'b1);
    chk("badcommit_err", int'(bus.cfg_err), 1);
    chk("badcommit_locked", int'(bus.locked), 0);
    chk("badcommit_ready", int'(bus.cfg_ready), 0);
    set_lk(0, 0, 0);
    cycle();
    clr_inputs();
    cycle();
    chk("unprog_lk_err", int'(bus.rsp_err[0]), 1);
    chk("unprog_lk_bank", d_bank(0), 0);

    // Full session with an illegal index and a same-cycle final write/commit.
    pulse(1'b1, 1'b0);
    chk("start_clears_err", int'(bus.cfg_err), 0);
    for (int i = 0; i < NE - 1; i++) write_entry(i);
    set_cfg(25, 1234, 1, 7);
    cycle();
    clr_inputs();
    chk("idx25_err", int'(bus.cfg_err), 1);
    pulse(1'b1, 1'b0);
    chk("start_in_load_err", int'(bus.cfg_err), 1);
    chk("start_in_load_ready", int'(bus.cfg_ready), 1);
    set_lk(1, 1, 0);
    cycle();
    clr_inputs();
    cycle();
    chk("load_lk_err", int'(bus.rsp_err[1]), 1);
    set_cfg(NE - 1, ent_base(NE - 1), ent_width(NE - 1), ent_fmt(NE - 1));
    bus.cfg_commit = 1'b1;
    cycle();
    clr_inputs();
    chk("commit_locked", int'(bus.locked), 1);

    // Entry 4 lookup.
    set_lk(0, 4, 0);
    cycle();
    clr_inputs();
    chk("e4_pipe_valid", int'(bus.rsp_valid[0]), 0);
    cycle();
    chk("e4_valid", int'(bus.rsp_valid[0]), 1);
    chk("e4_bank", d_bank(0), 1);
    chk("e4_addr", d_addr(0), 5664);
    chk("e4_width", int'(bus.rsp_width[0]), 1);
    chk("e4_fmt", int'(bus.rsp_fmt[0 +: FW]), 5);
    chk("e4_err", int'(bus.rsp_err[0]), 0);

    // Top-of-range boundary on entry 18.
    set_lk(0, 18, 9);
    set_lk(1, 18, 10);
    cycle();
    clr_inputs();
    cycle();
    chk("e18_last_bank", d_bank(0), 3);
    chk("e18_last_addr", d_addr(0), 14335);
    chk("e18_last_err", int'(bus.rsp_err[0]), 0);
    chk("e18_over_err", int'(bus.rsp_err[1]), 1);
    chk("e18_over_bank", d_bank(1), 0);
    chk("e18_over_addr", d_addr(1), 0);
    chk("e18_over_fmt", int'(bus.rsp_fmt[FW +: FW]), 2);

    // Back-to-back streaming on both ports.
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        set_lk(0, 0, 4095);
        set_lk(1, 2, 64);
      end
      cycle();
      clr_inputs();
      if (c >= 1 && c <= 10) begin
        chk("b2b_p0_addr", d_addr(0), 4095);
        chk("b2b_p1_addr", d_addr(1), 3904);
        chk("b2b_p1_bank", d_bank(1), 0);
      end
    end

    sweep();

    // Reprogram without writes, then a stray write while READY.
    pulse(1'b1, 1'b0);
    chk("restart_locked_drop", int'(bus.locked), 0);
    chk("restart_err_clear", int'(bus.cfg_err), 0);
    pulse(1'b0, 1'b1);
    chk("recommit_locked", int'(bus.locked), 1);
    set_cfg(3, 999, 1, 1);
    cycle();
    clr_inputs();
    chk("ready_write_err", int'(bus.cfg_err), 1);
    sweep();
    set_lk(1, 25, 0);
    cycle();
    clr_inputs();
    cycle();
    chk("badidx_err", int'(bus.rsp_err[1]), 1);
    chk("badidx_width", int'(bus.rsp_width[1]), 0);

    // Reset with lookups in flight.
    set_lk(0, 4, 1);
    set_lk(1, 2, 2);
    cycle();
    clr_inputs();
    rst = 1'b1;
    cycle();
    chk("rst_flush_valid", int'(bus.rsp_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    rst = 1'b0;
    set_lk(0, 4, 0);
    cycle();
    clr_inputs();
    cycle();
    chk("post_rst_err", int'(bus.rsp_err[0]), 1);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_res_map_table.md
Name: int_res_map_table

Overview:
- Runtime-programmable successor to the compile-time intermediate-result memory map and format tables.
- Holds one descriptor per data step: base address, data width and fixed-point format.
- Turns (step index, word offset) lookups into a bank select plus a bank-local address, with a range check.
- Sits between the inference controller and the CIM intermediate-result bank interface, so a new model layout needs only reprogramming, not a re-spin.

Parameters:
- NUM_ENTRIES, 20: number of descriptors (data steps).
- NUM_BANKS, 4: number of intermediate-result banks.
- BANK_SIZE, 14336: words per bank.
- ADDR_W, $clog2(NUM_BANKS*BANK_SIZE): width of flat addresses and offsets.
- FMT_W, 3: width of the fixed-point format code.
- NUM_PORTS, 2: number of independent lookup ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  open a programming session
- cfg_valid  in  1  descriptor write strobe
- cfg_ready  out  1  table accepts a write this cycle
- cfg_idx  in  $clog2(NUM_ENTRIES)  descriptor index
- cfg_base  in  ADDR_W  base flat address
- cfg_width  in  1  0 = single width, 1 = double width
- cfg_fmt  in  FMT_W  format code
- cfg_commit  in  1  close the session and lock the table
- cfg_err  out  1  sticky programming error
- locked  out  1  table is valid and serving lookups
- lk_valid  in  NUM_PORTS  lookup request, one bit per port
- lk_idx  in  NUM_PORTS*$clog2(NUM_ENTRIES)  step index per port
- lk_offset  in  NUM_PORTS*ADDR_W  word offset from base, per port
- rsp_valid  out  NUM_PORTS  response valid
- rsp_bank  out  NUM_PORTS*$clog2(NUM_BANKS)  bank select
- rsp_bank_addr  out  NUM_PORTS*$clog2(BANK_SIZE)  address within the bank
- rsp_width  out  NUM_PORTS  data width of the step
- rsp_fmt  out  NUM_PORTS*FMT_W  format code of the step
- rsp_err  out  NUM_PORTS  out-of-range or illegal lookup

Behaviour:
- Reset:
  - state = UNPROG.
  - Outputs cfg_ready, cfg_err, locked, all rsp_* = 0.
  - All descriptors cleared; the written-entry bitmap is cleared.
- State machine:
  - UNPROG: cfg_start -> LOAD.
  - LOAD:
    - cfg_ready = 1.
    - cfg_valid with cfg_idx < NUM_ENTRIES writes the entry and sets its written bit.
    - cfg_valid with cfg_idx >= NUM_ENTRIES is ignored and sets cfg_err.
    - cfg_commit:
      - All written bits set -> READY with locked = 1.
      - Otherwise -> UNPROG with cfg_err = 1.
  - READY:
    - Lookups are served.
    - cfg_valid is ignored and sets cfg_err.
    - cfg_start -> LOAD: locked drops the next cycle; the previous contents are kept until overwritten.
- Simultaneous cfg_valid and cfg_commit in LOAD: the write lands first, then the commit check includes that entry.
- cfg_start while in LOAD: no effect.
- cfg_err is cleared only by rst or by cfg_start.
- Lookup pipeline, fully pipelined, one request per port per cycle, 2-cycle latency:
  - Stage 1 (registered):
    - Compute flat = base + offset at ADDR_W+1 bits.
    - err = !locked or idx >= NUM_ENTRIES or flat >= NUM_BANKS*BANK_SIZE.
  - Stage 2 (registered):
    - Bank decode uses a compare chain against k*BANK_SIZE. No divider.
    - bank_addr = flat - bank*BANK_SIZE.
  - rsp_valid mirrors lk_valid delayed by 2 cycles.
  - When rsp_err = 1: rsp_bank and rsp_bank_addr are forced to 0; width and fmt still reflect the entry if idx is legal, else 0.
- The ports are independent; the same index on both ports in one cycle is legal.
- A table write in LOAD and a lookup on the same entry cannot coincide, because lookups in LOAD return err.
- Lookups already in flight when locked drops complete with their stage-1 err value.
- Mid-operation rst flushes the pipeline: rsp_valid = 0 the next cycle.

Test Plan:
- Program all 20 entries, entry 4 base 20000, width 1, fmt 5; commit; lookup (4, 0) -> locked = 1, after 2 cycles rsp_bank = 1, rsp_bank_addr = 5664, rsp_width = 1, rsp_fmt = 5, rsp_err = 0.
- Entry 18 base 57334: offset 9 -> bank 3, addr 14335, err 0. Offset 10 -> rsp_err = 1, bank 0, addr 0.
- Commit with entry 7 never written -> cfg_err = 1, locked = 0, state UNPROG; a subsequent lookup -> rsp_err = 1.
- Port 0 (0, 4095) and port 1 (2, 64) back-to-back for 10 cycles with entry 0 base 0 and entry 2 base 3840 -> every cycle after a 2-cycle latency: port 0 bank 0 addr 4095, port 1 bank 0 addr 3904.
- Write to idx 25 in LOAD -> cfg_err = 1, no entry changes. cfg_valid in READY -> cfg_err = 1, contents unchanged.
- Assert rst with 2 lookups in flight -> rsp_valid = 0 the next cycle, locked = 0; a lookup after rst -> rsp_err = 1.
